acc_ctrl_sequencer: RTL
=======================

Name: acc_ctrl_sequencer

Overview:
- Control unit for the accumulator processor. It sequences the load/store register bank (PC, MAR, IR, ACC, each built from n-bit ld/st registers) through fetch, decode and execute.
- It produces per-register load strobes, mux selects, ALU op and memory read/write.
- It handshakes with memory through mem_ready.
- It sits between the instruction register output and the datapath enables.

Parameters:
- OP_W, 3, opcode width (IR[7:5]).
- ST_W, 3, width of the debug state output.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- start  input  1  begin execution; sampled only in IDLE.
- ir_opcode  input  OP_W  opcode field from the IR register output.
- acc_zero  input  1  high when ACC == 0.
- mem_ready  input  1  memory has completed the current read or write.
- ld_pc  output  1  PC load from IR operand (jump).
- inc_pc  output  1  PC increment.
- ld_mar  output  1  MAR load.
- mar_sel  output  1  MAR source: 0 = PC, 1 = IR operand.
- ld_ir  output  1  IR load from memory data.
- ld_acc  output  1  ACC load.
- acc_sel  output  1  ACC source: 0 = ALU result, 1 = memory data.
- alu_op  output  2  00 = ADD, 01 = SUB, 10 = AND, 11 = pass.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request (data = ACC).
- halted  output  1  processor stopped by HLT.
- state  output  ST_W  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE = 0, FETCH_A = 1, FETCH_M = 2, DECODE = 3, EXEC_M = 4, HALT = 5. Encodings 6 and 7 are illegal and go to IDLE on the next clock.
- Outputs are combinational decodes of state, the latched opcode, mem_ready and acc_zero. The datapath captures on the next clk edge.
- Any output not listed for a state is 0.
- Reset: clr low forces IDLE immediately (no clock needed).
  - All outputs 0, halted 0, latched opcode 000.
  - Reset in any state, including a pending memory wait, aborts the operation with no further strobes.
- IDLE: start = 1 -> FETCH_A; otherwise stay.
- FETCH_A: mar_sel = 0, ld_mar = 1 -> FETCH_M.
- FETCH_M: mem_rd = 1.
  - If mem_ready: ld_ir = 1, inc_pc = 1 -> DECODE.
  - Else stay in FETCH_M with mem_rd held and no other strobes.
- DECODE: capture ir_opcode into the internal opcode register, then branch:
  - 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 AND: mar_sel = 1, ld_mar = 1 -> EXEC_M.
  - 101 JMP: ld_pc = 1 -> FETCH_A.
  - 110 JZ: ld_pc = acc_zero -> FETCH_A (always moves on, taken or not).
  - 111 HLT: -> HALT.
- EXEC_M (uses the latched opcode only; changes on ir_opcode are ignored):
  - LDA: mem_rd = 1; on mem_ready: ld_acc = 1, acc_sel = 1.
  - STA: mem_wr = 1; on mem_ready: completes with no load.
  - ADD/SUB/AND: mem_rd = 1, alu_op = 00/01/10; on mem_ready: ld_acc = 1, acc_sel = 0.
  - mem_ready = 1 -> FETCH_A. mem_ready = 0 -> stay, with request and alu_op held stable.
- HALT: halted = 1, all strobes 0. start is ignored; only clr exits.
- Exclusivity: mem_rd and mem_wr are never both 1. ld_pc and inc_pc are never both 1.
- Latency with zero-wait memory (mem_ready tied high):
  - LDA/STA/ADD/SUB/AND: 4 cycles.
  - JMP/JZ: 3 cycles.
  - HLT: 3 cycles to HALT.
- Each cycle of mem_ready low adds one cycle in FETCH_M or EXEC_M.
- start held high continuously has no effect outside IDLE.

Test Plan:
- Reset/idle: clr = 0 mid-EXEC_M with mem_rd = 1 -> same cycle state = 0 and all outputs 0. Release clr with start = 0 for 5 cycles -> stays in state 0.
- LDA, zero-wait: start pulse, ir_opcode = 000, mem_ready = 1 -> state sequence 1, 2, 3, 4, 1. Strobes in order: ld_mar (mar_sel = 0); ld_ir + inc_pc; ld_mar (mar_sel = 1); ld_acc + acc_sel = 1.
- ADD with 2 wait cycles in EXEC_M: mem_ready low for 2 cycles -> state 4 held 3 cycles with mem_rd = 1 and alu_op = 00 throughout. ld_acc pulses exactly once, in the cycle mem_ready = 1.
- JZ: opcode 110 with acc_zero = 1 -> ld_pc = 1 in DECODE. With acc_zero = 0 -> ld_pc = 0. Both cases return to state 1.
- STA with opcode disturbance: change ir_opcode to 111 during EXEC_M -> mem_wr = 1 is held until mem_ready, ld_acc stays 0, and next state is 1 (not HALT).
- HLT: opcode 111 -> state 5, halted = 1. Pulse start -> no change. Assert clr -> state 0, halted = 0.

Source files
------------

// File: rtl/acc_ctrl_sequencer.sv
// rtl/acc_ctrl_sequencer.sv - fetch/decode/execute control FSM for the accumulator processor
// Drives register-bank load strobes, mux selects, ALU op and memory requests.
module acc_ctrl_sequencer #(
   parameter int OP_W = 3,
   parameter int ST_W = 3
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic [OP_W-1:0] ir_opcode,
   input  logic            acc_zero,
   input  logic            mem_ready,
   output logic            ld_pc,
   output logic            inc_pc,
   output logic            ld_mar,
   output logic            mar_sel,
   output logic            ld_ir,
   output logic            ld_acc,
   output logic            acc_sel,
   output logic [1:0]      alu_op,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            halted,
   output logic [ST_W-1:0] state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH_A = 3'd1,
      S_FETCH_M = 3'd2,
      S_DECODE  = 3'd3,
      S_EXEC_M  = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   localparam logic [OP_W-1:0] OP_LDA = OP_W'(0);
   localparam logic [OP_W-1:0] OP_STA = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
   localparam logic [OP_W-1:0] OP_AND = OP_W'(4);
   localparam logic [OP_W-1:0] OP_JMP = OP_W'(5);
   localparam logic [OP_W-1:0] OP_JZ  = OP_W'(6);

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;

   state_t          state_q;
   state_t          state_d;
   logic [OP_W-1:0] op_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= ir_opcode;
         end
      end
   end

   // DECODE branches on the live IR field; EXEC_M only ever sees the latched copy.
   always_comb begin
      state_d = state_q;
      ld_pc   = 1'b0;
      inc_pc  = 1'b0;
      ld_mar  = 1'b0;
      mar_sel = 1'b0;
      ld_ir   = 1'b0;
      ld_acc  = 1'b0;
      acc_sel = 1'b0;
      alu_op  = ALU_ADD;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      halted  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH_A;
            end
         end

         S_FETCH_A: begin
            ld_mar  = 1'b1;
            state_d = S_FETCH_M;
         end

         S_FETCH_M: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ld_ir   = 1'b1;
               inc_pc  = 1'b1;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            case (ir_opcode)
               OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND: begin
                  mar_sel = 1'b1;
                  ld_mar  = 1'b1;
                  state_d = S_EXEC_M;
               end
               OP_JMP: begin
                  ld_pc   = 1'b1;
                  state_d = S_FETCH_A;
               end
               OP_JZ: begin
                  ld_pc   = acc_zero;
                  state_d = S_FETCH_A;
               end
               default: begin
                  state_d = S_HALT;
               end
            endcase
         end

         S_EXEC_M: begin
            case (op_q)
               OP_LDA: begin
                  mem_rd  = 1'b1;
                  ld_acc  = mem_ready;
                  acc_sel = mem_ready;
               end
               OP_STA: begin
                  mem_wr = 1'b1;
               end
               OP_ADD: begin
                  mem_rd = 1'b1;
                  alu_op = ALU_ADD;
                  ld_acc = mem_ready;
               end
               OP_SUB: begin
                  mem_rd = 1'b1;
                  alu_op = ALU_SUB;
                  ld_acc = mem_ready;
               end
               OP_AND: begin
                  mem_rd = 1'b1;
                  alu_op = ALU_AND;
                  ld_acc = mem_ready;
               end
               default: begin
               end
            endcase
            if (mem_ready) begin
               state_d = S_FETCH_A;
            end
         end

         S_HALT: begin
            halted = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign state = ST_W'(state_q);

endmodule
